// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, in-order imem requests, credit-limited instruction buffer, redirect flush.
// FETCH_MISALIGN_CHECK_EN: halt fetch and flag misaligned redirect targets until an aligned redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        fetch_misaligned
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] live_count;
    logic [CW-1:0] stale_count;
    logic [SW-1:0] credit_used;
    logic [31:0]   redirect_base;
    logic          halted;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          resp_stale;

    assign redirect_base = {redirect_pc[31:2], 2'b00};

    // Every buffer slot is reserved at request time, so pushes never overflow.
    assign credit_used = SW'(live_count) + SW'(stale_count) + SW'(fifo_count);

    assign imem_req_valid = !rst && !redirect_valid && !halted
                            && (credit_used < DEPTH_S);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_stale = imem_resp_valid && (stale_count != '0);
    assign push       = imem_resp_valid && (stale_count == '0)
                        && !redirect_valid;

    assign out_valid       = (fifo_count != '0);
    assign pop             = out_valid && out_ready;
    assign out_instruction = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc          = out_valid ? buf_pc[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_resp_data;
            buf_pc[wr_ptr]    <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            live_count  <= '0;
            stale_count <= '0;
        end else if (redirect_valid) begin
            // A response landing now belongs to the old stream.
            fetch_pc    <= redirect_base;
            resp_pc     <= redirect_base;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            live_count  <= '0;
            stale_count <= stale_count + live_count
                           - CW'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (resp_stale) begin
                stale_count <= stale_count - CW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            live_count <= live_count + CW'(req_fire) - CW'(push);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= |redirect_pc[1:0];
        end
    end
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign halted = 1'b0;
`endif

    assign fetch_misaligned = halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-programmable in-order memory model.
// Inputs change 1 time unit after posedge; outputs are checked on negedge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        fetch_misaligned;

    int n_checks = 0;
    int n_fail = 0;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    // Memory model: returns the request address as data, lat cycles later.
    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       q[$];
    int          lat = 1;
    bit          model_en = 1'b1;
    int          cyc = 0;
    logic        p_req = 1'b0;
    logic        p_resp = 1'b0;
    logic        p_rst = 1'b1;
    logic [31:0] p_addr = '0;

    always @(negedge clk) begin
        p_req  = imem_req_valid && imem_req_ready;
        p_addr = imem_req_addr;
        p_resp = imem_resp_valid;
        p_rst  = rst;
    end

    always @(posedge clk) begin
        #1;
        if (p_rst) begin
            q.delete();
        end else begin
            if (p_resp && q.size() > 0) q.delete(0);
            if (p_req) q.push_back('{p_addr, cyc + lat});
        end
        cyc++;
        if (model_en) begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = q[0].addr;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns positioned in the first cycle after reset release.
    task automatic do_reset(input int l, input logic ordy, input bit men);
        tick();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = ordy;
        lat            = l;
        model_en       = men;
        if (!men) begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        n_checks++;
        if (imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_req_addr: got %h want 0", imem_req_addr);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_instruction !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_instr: got %h want 0", out_instruction);
        end
        n_checks++;
        if (out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_pc: got %h want 0", out_pc);
        end
        n_checks++;
        if (fetch_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_misaligned: got %b want 0", fetch_misaligned);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ea;
        logic [31:0] eo;
        logic        ev;
        do_reset(1, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) tick();
            @(negedge clk);
            ea = 32'(4 * (i - 1));
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== ea) begin
                n_fail++;
                $display("FAIL stream_req c%0d: got v=%b a=%h want v=1 a=%h",
                         i, imem_req_valid, imem_req_addr, ea);
            end
            ev = (i >= 3);
            eo = ev ? 32'(4 * (i - 3)) : 32'h0;
            n_checks++;
            if (out_valid !== ev || (ev && (out_pc !== eo
                                    || out_instruction !== eo))) begin
                n_fail++;
                $display("FAIL stream_out c%0d: got v=%b pc=%h i=%h want v=%b pc=%h",
                         i, out_valid, out_pc, out_instruction, ev, eo);
            end
        end
    endtask

    task automatic test_backpressure();
        int fires;
        fires = 0;
        do_reset(1, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) tick();
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) fires++;
        end
        n_checks++;
        if (fires != 4) begin
            n_fail++;
            $display("FAIL bp_fire_count: got %0d want 4", fires);
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_full: got rv=%b ov=%b pc=%h want rv=0 ov=1 pc=0",
                     imem_req_valid, out_valid, out_pc);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release_cycle: got rv=%b want 0", imem_req_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL bp_resume: got v=%b a=%h want v=1 a=00000010",
                     imem_req_valid, imem_req_addr);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL bp_next_out: got v=%b pc=%h want v=1 pc=00000004",
                     out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_stale();
        int k;
        bit found;
        do_reset(3, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_redirect_cycle: got rv=%b ov=%b want 0 0",
                     imem_req_valid, out_valid);
        end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL stale_first_req: got v=%b a=%h want v=1 a=00000100",
                     imem_req_valid, imem_req_addr);
        end
        found = 1'b0;
        k = 0;
        while (!found && k < 20) begin
            tick();
            k++;
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stale_timeout: got no out_valid in 20 cycles want pc 00000100");
        end else if (out_pc !== 32'h100 || out_instruction !== 32'h100 || k != 4) begin
            n_fail++;
            $display("FAIL stale_first_out: got pc=%h i=%h at +%0d want pc=00000100 at +4",
                     out_pc, out_instruction, k);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL stale_second_out: got v=%b pc=%h want v=1 pc=00000104",
                     out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset(1, 1'b0, 1'b0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hAAAA_0000;
        tick();
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL col_setup: got v=%b pc=%h i=%h want v=1 pc=0 i=aaaa0000",
                     out_valid, out_pc, out_instruction);
        end
        tick();
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h100;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBBBB_0004;
        out_ready       = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL col_beat: got ov=%b pc=%h rv=%b want ov=1 pc=0 rv=0",
                     out_valid, out_pc, imem_req_valid);
        end
        tick();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        out_ready       = 1'b0;
        imem_req_ready  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL col_flushed: got ov=%b want 0", out_valid);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL col_new_req: got v=%b a=%h want v=1 a=00000100",
                     imem_req_valid, imem_req_addr);
        end
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCCCC_0100;
        tick();
        imem_resp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instruction !== 32'hCCCC_0100) begin
            n_fail++;
            $display("FAIL col_new_out: got v=%b pc=%h i=%h want v=1 pc=00000100 i=cccc0100",
                     out_valid, out_pc, out_instruction);
        end
    endtask

    task automatic test_misalign();
        do_reset(1, 1'b1, 1'b1);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        n_checks++;
        if (fetch_misaligned !== 1'b1 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_set: got flag=%b rv=%b want flag=1 rv=0",
                     fetch_misaligned, imem_req_valid);
        end
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || fetch_misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_halted: got rv=%b ov=%b flag=%b want 0 0 1",
                     imem_req_valid, out_valid, fetch_misaligned);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1
            || imem_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL mis_resume: got flag=%b v=%b a=%h want flag=0 v=1 a=00000200",
                     fetch_misaligned, imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL mis_resume_out: got v=%b pc=%h want v=1 pc=00000200",
                     out_valid, out_pc);
        end
`else
        n_checks++;
        if (fetch_misaligned !== 1'b0 || imem_req_valid !== 1'b1
            || imem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL unal_req: got flag=%b v=%b a=%h want flag=0 v=1 a=00000100",
                     fetch_misaligned, imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instruction !== 32'h100) begin
            n_fail++;
            $display("FAIL unal_out: got v=%b pc=%h i=%h want v=1 pc=00000100",
                     out_valid, out_pc, out_instruction);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset(1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instruction !== 32'h0
            || imem_req_valid !== 1'b0 || fetch_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: got ov=%b pc=%h i=%h rv=%b f=%b want all 0",
                     out_valid, out_pc, out_instruction, imem_req_valid, fetch_misaligned);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_restart: got v=%b a=%h want v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collide();
        test_misalign();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RV32I pipeline, directly upstream of the instruction decoder. Holds the fetch PC, issues in-order word requests to instruction memory over a valid/ready handshake, buffers returned instruction words with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. A redirect from the branch/jump resolution logic flushes the buffer and discards in-flight responses belonging to the old stream.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥ 2; also the cap on outstanding memory requests
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- imem_req_valid  output  1  request to instruction memory
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address
- imem_resp_valid  input  1  response word valid; responses return strictly in request order, ≥ 1 cycle after acceptance
- imem_resp_data  input  32  instruction word
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch PC
- out_valid  output  1  instruction available to decode
- out_ready  input  1  decode accepts instruction
- out_instruction  output  32  instruction word
- out_pc  output  32  PC of out_instruction
- fetch_misaligned  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: fetch_pc, resp_pc, FIFO (instruction + PC), fifo_count, live_count (outstanding requests of current stream), stale_count (outstanding requests of flushed streams).
- Request issue: imem_req_valid = !redirect_valid && !halted && (live_count + stale_count + fifo_count < FIFO_DEPTH). imem_req_addr = fetch_pc. On handshake: fetch_pc += 4 (mod 2^32), live_count++.
- Response: if stale_count > 0, drop word, stale_count--. Otherwise push {imem_resp_data, resp_pc} into FIFO, resp_pc += 4, live_count--. Credit rule guarantees FIFO never overflows.
- Output: out_valid = fifo_count > 0; head entry drives out_instruction/out_pc; pop on out_valid && out_ready.
- Redirect (highest priority): FIFO cleared; fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}; stale_count += live_count, live_count = 0. A response arriving in the redirect cycle is treated as stale (counted against the pre-redirect totals). An out handshake in the redirect cycle completes (decode owns that beat); FIFO still ends empty. No request issued in redirect cycle.
- Counter widths: $clog2(FIFO_DEPTH)+1 bits; saturation impossible by credit rule.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, out_valid 0, out_instruction 0, out_pc 0, fetch_misaligned 0; all counters 0; fetch_pc = resp_pc = RESET_PC.
- First request asserted in the first cycle after rst deasserts, addr RESET_PC.
- Response accepted in cycle N → out_valid in cycle N+1 (registered FIFO); no combinational path imem_resp_* → out_*.
- out_valid and out_* depend on registers only. imem_req_valid depends combinationally only on redirect_valid.
- First request of new stream issued in cycle after redirect.
- Sustained 1 instruction/cycle with 1-cycle memory latency and out_ready held high.
- rst mid-operation: all state returns to reset values; responses to pre-reset requests are the memory's responsibility (memory is reset together).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets fetch_misaligned (from next cycle), clears FIFO as a normal redirect, and halts fetch (imem_req_valid 0) until a subsequent aligned redirect, which clears fetch_misaligned and resumes.
- Undefined: redirect_pc[1:0] ignored (forced 00), fetch never halts, fetch_misaligned tied 0.

## Test plan
- Reset release, 1-cycle memory returning addr-as-data, out_ready=1 → addrs 0,4,8,… issued back-to-back; out_pc 0 appears cycle after first response, then one per cycle.
- out_ready=0, memory always ready → exactly FIFO_DEPTH (4) requests issued, then imem_req_valid stays 0; releasing out_ready resumes issue within 1 cycle.
- 3-cycle memory latency, redirect to 0x100 with 3 requests in flight → those 3 responses dropped; first out_pc is 0x100, no stale instruction ever reaches out_valid.
- redirect, response and out handshake in same cycle → response dropped, out beat consumed, next cycle out_valid 0, imem_req_addr 0x100.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 → fetch_misaligned 1, no requests; redirect to 0x200 → flag 0, fetch resumes at 0x200. Without macro: 0x102 fetches from 0x100.
